// File: rtl/pipe_latch_bank_pkg.sv
// rtl/pipe_latch_bank_pkg.sv - shared word width, NOP encoding and opcode field helpers
package pipe_latch_bank_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_IR = 32'h0000_0000;

  // Opcode field position, used by the processor-side bubble logic.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef logic [OPC_W-1:0] opcode_t;

  function automatic opcode_t get_opcode(input logic [WORD_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_nop(input logic [WORD_W-1:0] ir);
    return ir == NOP_IR;
  endfunction

endpackage

// File: rtl/pipe_latch_bank_if.sv
// rtl/pipe_latch_bank_if.sv - stage inputs/enables and latched outputs of the FD, DX and MW latches
interface pipe_latch_bank_if
  import pipe_latch_bank_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic             fd_en;
  logic [WIDTH-1:0] fd_in_ir;
  logic [WIDTH-1:0] fd_in_pc;
  logic [WIDTH-1:0] fd_out_ir;
  logic [WIDTH-1:0] fd_out_pc;

  logic             dx_en;
  logic [WIDTH-1:0] dx_in_ir;
  logic [WIDTH-1:0] dx_in_pc;
  logic [WIDTH-1:0] dx_in_a;
  logic [WIDTH-1:0] dx_in_b;
  logic [WIDTH-1:0] dx_out_ir;
  logic [WIDTH-1:0] dx_out_pc;
  logic [WIDTH-1:0] dx_out_a;
  logic [WIDTH-1:0] dx_out_b;

  logic             mw_en;
  logic [WIDTH-1:0] mw_in_ir;
  logic [WIDTH-1:0] mw_in_pc;
  logic [WIDTH-1:0] mw_in_o;
  logic [WIDTH-1:0] mw_in_d;
  logic [WIDTH-1:0] mw_out_ir;
  logic [WIDTH-1:0] mw_out_pc;
  logic [WIDTH-1:0] mw_out_o;
  logic [WIDTH-1:0] mw_out_d;

  // Processor side: drives stage inputs, consumes latched values.
  modport master (
    output fd_en, fd_in_ir, fd_in_pc,
    output dx_en, dx_in_ir, dx_in_pc, dx_in_a, dx_in_b,
    output mw_en, mw_in_ir, mw_in_pc, mw_in_o, mw_in_d,
    input  fd_out_ir, fd_out_pc,
    input  dx_out_ir, dx_out_pc, dx_out_a, dx_out_b,
    input  mw_out_ir, mw_out_pc, mw_out_o, mw_out_d
  );

  // Latch bank side.
  modport slave (
    input  fd_en, fd_in_ir, fd_in_pc,
    input  dx_en, dx_in_ir, dx_in_pc, dx_in_a, dx_in_b,
    input  mw_en, mw_in_ir, mw_in_pc, mw_in_o, mw_in_d,
    output fd_out_ir, fd_out_pc,
    output dx_out_ir, dx_out_pc, dx_out_a, dx_out_b,
    output mw_out_ir, mw_out_pc, mw_out_o, mw_out_d
  );

endinterface

// File: rtl/pipe_latch_bank_pipe_reg.sv
// rtl/pipe_latch_bank_pipe_reg.sv - WIDTH-bit enabled register with async active-low clear
module pipe_reg
  import pipe_latch_bank_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_latch_bank.sv
// rtl/pipe_latch_bank.sv - FD, DX and MW pipeline latch sets, one pipe_reg per field
module pipe_latch_bank
  import pipe_latch_bank_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               clock,
  input  logic               reset,
  pipe_latch_bank_if.slave   bus
);

  // Every field of a stage shares that stage's enable so a stage never updates partially.
  pipe_reg #(.WIDTH(WIDTH)) u_fd_ir (
    .clock (clock), .reset (reset), .en (bus.fd_en),
    .d     (bus.fd_in_ir), .q (bus.fd_out_ir)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_fd_pc (
    .clock (clock), .reset (reset), .en (bus.fd_en),
    .d     (bus.fd_in_pc), .q (bus.fd_out_pc)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_dx_ir (
    .clock (clock), .reset (reset), .en (bus.dx_en),
    .d     (bus.dx_in_ir), .q (bus.dx_out_ir)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_dx_pc (
    .clock (clock), .reset (reset), .en (bus.dx_en),
    .d     (bus.dx_in_pc), .q (bus.dx_out_pc)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_dx_a (
    .clock (clock), .reset (reset), .en (bus.dx_en),
    .d     (bus.dx_in_a), .q (bus.dx_out_a)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_dx_b (
    .clock (clock), .reset (reset), .en (bus.dx_en),
    .d     (bus.dx_in_b), .q (bus.dx_out_b)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_mw_ir (
    .clock (clock), .reset (reset), .en (bus.mw_en),
    .d     (bus.mw_in_ir), .q (bus.mw_out_ir)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_mw_pc (
    .clock (clock), .reset (reset), .en (bus.mw_en),
    .d     (bus.mw_in_pc), .q (bus.mw_out_pc)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_mw_o (
    .clock (clock), .reset (reset), .en (bus.mw_en),
    .d     (bus.mw_in_o), .q (bus.mw_out_o)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_mw_d (
    .clock (clock), .reset (reset), .en (bus.mw_en),
    .d     (bus.mw_in_d), .q (bus.mw_out_d)
  );

endmodule

// File: tb/tb_pipe_latch_bank.sv
// tb/tb_pipe_latch_bank.sv - directed self-checking bench for pipe_latch_bank
module tb_pipe_latch_bank;
  import pipe_latch_bank_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipe_latch_bank_if #(.WIDTH(32)) bus ();

  pipe_latch_bank #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fd(input string tag, input logic [31:0] ir, input logic [31:0] pc);
    chk({tag, ".fd_ir"}, bus.fd_out_ir, ir);
    chk({tag, ".fd_pc"}, bus.fd_out_pc, pc);
  endtask

  task automatic chk_dx(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
    chk({tag, ".dx_ir"}, bus.dx_out_ir, ir);
    chk({tag, ".dx_pc"}, bus.dx_out_pc, pc);
    chk({tag, ".dx_a"},  bus.dx_out_a,  a);
    chk({tag, ".dx_b"},  bus.dx_out_b,  b);
  endtask

  task automatic chk_mw(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] o, input logic [31:0] d);
    chk({tag, ".mw_ir"}, bus.mw_out_ir, ir);
    chk({tag, ".mw_pc"}, bus.mw_out_pc, pc);
    chk({tag, ".mw_o"},  bus.mw_out_o,  o);
    chk({tag, ".mw_d"},  bus.mw_out_d,  d);
  endtask

  task automatic drive_all(input logic [31:0] v, input logic en);
    bus.fd_en = en; bus.dx_en = en; bus.mw_en = en;
    bus.fd_in_ir = v; bus.fd_in_pc = v;
    bus.dx_in_ir = v; bus.dx_in_pc = v; bus.dx_in_a = v; bus.dx_in_b = v;
    bus.mw_in_ir = v; bus.mw_in_pc = v; bus.mw_in_o = v; bus.mw_in_d = v;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    drive_all(32'h0, 1'b0);

    // Power-up reset state.
    #2;
    chk_fd("por", NOP_IR, 32'h0);
    chk_dx("por", NOP_IR, 32'h0, 32'h0, 32'h0);
    chk_mw("por", NOP_IR, 32'h0, 32'h0, 32'h0);

    // Release, load all-ones everywhere.
    @(negedge clock);
    reset = 1'b1;
    drive_all(32'hFFFF_FFFF, 1'b1);
    @(posedge clock); #1;
    chk_fd("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_dx("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Async reset between edges clears before the next edge; an edge during reset is ignored.
    #2 reset = 1'b0;
    #1;
    chk_fd("async_rst", 32'h0, 32'h0);
    chk_dx("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    chk_mw("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clock); #1;
    chk_fd("edge_in_rst", 32'h0, 32'h0);
    chk_mw("edge_in_rst", 32'h0, 32'h0, 32'h0, 32'h0);

    // First edge after release loads all-ones.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_fd("rel_load", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_dx("rel_load", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_mw("rel_load", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // FD capture then hold.
    @(negedge clock);
    bus.dx_en = 1'b0; bus.mw_en = 1'b0;
    bus.fd_en = 1'b1; bus.fd_in_ir = 32'h2800_0005; bus.fd_in_pc = 32'd7;
    @(posedge clock); #1;
    chk_fd("fd_cap", 32'h2800_0005, 32'd7);
    chk_dx("dx_held", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clock);
    bus.fd_en = 1'b0; bus.fd_in_ir = 32'h1234_5678; bus.fd_in_pc = 32'd99;
    @(posedge clock); #1;
    chk_fd("fd_hold", 32'h2800_0005, 32'd7);

    // DX pass-through of bubble and extreme operands.
    @(negedge clock);
    bus.dx_en = 1'b1;
    bus.dx_in_ir = 32'h0; bus.dx_in_pc = 32'd12;
    bus.dx_in_a = 32'h8000_0000; bus.dx_in_b = 32'h7FFF_FFFF;
    @(posedge clock); #1;
    chk_dx("dx_pass", 32'h0, 32'd12, 32'h8000_0000, 32'h7FFF_FFFF);

    // MW capture only at the edge; mid-cycle input changes do not leak through.
    @(negedge clock);
    bus.dx_en = 1'b0;
    bus.mw_en = 1'b1;
    bus.mw_in_ir = 32'h4000_0003; bus.mw_in_pc = 32'd20;
    bus.mw_in_o = 32'd100; bus.mw_in_d = 32'hDEAD_BEEF;
    #1;
    chk_mw("mw_pre_edge", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    chk_mw("mw_cap", 32'h4000_0003, 32'd20, 32'd100, 32'hDEAD_BEEF);
    #2;
    bus.mw_in_ir = 32'h5555_5555; bus.mw_in_o = 32'hAAAA_AAAA; bus.mw_in_d = 32'h0;
    #1;
    chk_mw("mw_mid", 32'h4000_0003, 32'd20, 32'd100, 32'hDEAD_BEEF);

    // Independent enables: FD stalled, DX/MW stream for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.fd_en = 1'b0; bus.dx_en = 1'b1; bus.mw_en = 1'b1;
      bus.fd_in_ir = 32'hF000_0000 + i; bus.fd_in_pc = 32'h50 + i;
      bus.dx_in_ir = 32'h0100_0000 + i; bus.dx_in_pc = 32'h10 + i;
      bus.dx_in_a  = 32'hA000_0000 + i; bus.dx_in_b  = 32'hB000_0000 + i;
      bus.mw_in_ir = 32'h0200_0000 + i; bus.mw_in_pc = 32'h20 + i;
      bus.mw_in_o  = 32'hC000_0000 + i; bus.mw_in_d  = 32'hD000_0000 + i;
      @(posedge clock); #1;
      chk_fd($sformatf("indep%0d", i), 32'h2800_0005, 32'd7);
      chk_dx($sformatf("indep%0d", i), 32'h0100_0000 + i, 32'h10 + i,
             32'hA000_0000 + i, 32'hB000_0000 + i);
      chk_mw($sformatf("indep%0d", i), 32'h0200_0000 + i, 32'h20 + i,
             32'hC000_0000 + i, 32'hD000_0000 + i);
    end

    // Reset while FD is holding a nonzero value.
    @(negedge clock);
    bus.dx_en = 1'b0; bus.mw_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_fd("rst_hold", 32'h0, 32'h0);
    chk_dx("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0);
    chk_mw("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_latch_bank.md
# pipe_latch_bank

Bank of the three word-wide pipeline latches of the 5-stage processor: Fetch/Decode (FD), Decode/Execute (DX) and Memory/Writeback (MW). Each latch set captures its stage inputs on the clock edge when its enable is high and holds otherwise. All outputs clear to zero on reset; an all-zero IR is the pipeline NOP. Bubble and flush insertion (forcing IR to 0) is done by the surrounding processor on the inputs, not inside this block.

## Interface
Parameters:
- `WIDTH`, default 32: width of every IR/PC/data word.

Ports:
- `clock` in 1: single clock. All capture happens on its rising edge. The processor connects its inverted master clock here.
- `reset` in 1: asynchronous, active-low. Clears every output.
- `fd_en` in 1: FD capture enable.
- `fd_in_ir` in WIDTH: fetched instruction.
- `fd_in_pc` in WIDTH: PC value for the FD stage.
- `fd_out_ir`, `fd_out_pc` out WIDTH: latched FD instruction and PC.
- `dx_en` in 1: DX capture enable.
- `dx_in_ir`, `dx_in_pc` in WIDTH: instruction and PC.
- `dx_in_a`, `dx_in_b` in WIDTH: register file read data A and B.
- `dx_out_ir`, `dx_out_pc`, `dx_out_a`, `dx_out_b` out WIDTH: latched DX values.
- `mw_en` in 1: MW capture enable.
- `mw_in_ir`, `mw_in_pc` in WIDTH: instruction and PC.
- `mw_in_o` in WIDTH: ALU/address result.
- `mw_in_d` in WIDTH: dmem read data.
- `mw_out_ir`, `mw_out_pc`, `mw_out_o`, `mw_out_d` out WIDTH: latched MW values.

## Operation
- Each stage is independent. On a rising `clock` edge with `reset` high:
  - stage enable = 1: every output of that stage takes its corresponding input.
  - stage enable = 0: every output of that stage holds its value.
- All fields within a stage share the stage enable, so a stage never updates partially.
- No combinational path from any input to any output. Outputs are register Q only.
- Data is passed unmodified: no decoding, no sign-extension, no zeroing of IR.
- Reset (`reset` = 0) clears all 10 outputs to 0 immediately, independent of `clock` and the enables. The zero IR acts as a NOP in every stage.
- Reset release is not required to be synchronized here. The first capture occurs on the first rising edge at which `reset` = 1.
- Stall usage in the processor:
  - `fd_en` is low during load-use and mult/div stalls, so FD holds.
  - `dx_en` and `mw_en` are tied high.
  - Bubbles arrive as `dx_in_ir` = 0.

## Timing
- Latency is 1 clock from input to output for every field, whenever the stage enable is high.
- Each enable is sampled at the same edge as the data it gates.
- If `reset` is asserted mid-operation, the outputs go to 0 asynchronously. Any edge during reset is ignored.
- A stage whose enable is low across many cycles holds its value indefinitely.
- There is no full/empty state and no wrap-around. Every stage is a single-entry register.

## Structure
- Sub-module `pipe_reg`: a WIDTH-bit register with enable and async active-low clear to 0. It is instantiated once per field, 10 instances in total.
- Shared package holds:
  - `WORD_W` = 32.
  - `NOP_IR` = 32'h0000_0000.
  - Opcode field position [31:27], used by the processor-side logic that generates bubbles.

## Test plan
- Reset:
  - Drive all inputs to 32'hFFFF_FFFF with all enables = 1, then pull `reset` low between edges. All outputs must read 0 before the next edge.
  - After release, the first edge must load 32'hFFFF_FFFF.
- FD capture:
  - Input `fd_in_ir` = 32'h2800_0005, `fd_in_pc` = 7, `fd_en` = 1. After one edge, outputs show the same values.
  - Next cycle, set `fd_en` = 0 with new inputs. Outputs must hold 32'h2800_0005 and 7.
- DX pass-through:
  - Input IR = 32'h0000_0000 (bubble), PC = 12, A = 32'h8000_0000, B = 32'h7FFF_FFFF. After one edge, all four outputs must match exactly, with no sign change.
- MW capture:
  - Input IR = 32'h4000_0003, O = 100, D = 32'hDEAD_BEEF. The outputs must reflect these values only after the edge; changing the inputs mid-cycle must not alter the outputs.
- Independent enables:
  - Toggle `fd_en` = 0 while `dx_en` = `mw_en` = 1 for 3 cycles with changing inputs. FD must hold while DX and MW update every edge.
- Reset during hold:
  - With `fd_en` = 0 and nonzero held values, assert `reset`. The FD outputs must clear to 0.
